addsub_rr_server: RTL and testbench



---
 rtl/addsub_rr_server.sv | 108 ++++++++++
 tb/tb_addsub_rr_server.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_server.sv
// Registered add/sub responder: round-robin arbitration over four requester ports.
// Optional build macro ADDSUB_FIXED_PRIO_EN selects fixed priority (port 3 highest).
module addsub_rr_server #(
  parameter int W  = 8,
  parameter int NP = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NP-1:0] req_i,
  input  logic [2*W:0]  op0_i,
  input  logic [2*W:0]  op1_i,
  input  logic [2*W:0]  op2_i,
  input  logic [2*W:0]  op3_i,
  output logic [NP-1:0] ready_o,
  output logic [W-1:0]  res_o,
  output logic          carry_o,
  output logic [1:0]    gidx_o,
  output logic          busy_o
);

  logic [NP-1:0] r_ready;
  logic [W-1:0]  r_res;
  logic          r_carry;
  logic [1:0]    r_gidx;
`ifndef ADDSUB_FIXED_PRIO_EN
  logic [1:0]    r_ptr;
  logic [1:0]    w_idx;
`endif

  logic [NP-1:0] w_elig;
  logic [1:0]    w_win;
  logic          w_found;
  logic [2*W:0]  w_op;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_mode;
  logic [W:0]    w_sum;

  // A port is masked during the cycle its result is presented.
  assign w_elig = req_i & ~r_ready;

  always_comb begin
    w_win   = 2'd0;
    w_found = 1'b0;
`ifdef ADDSUB_FIXED_PRIO_EN
    for (int i = NP - 1; i >= 0; i--) begin
      if (!w_found && w_elig[i]) begin
        w_win   = 2'(i);
        w_found = 1'b1;
      end
    end
`else
    w_idx = 2'd0;
    for (int i = 0; i < NP; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    case (w_win)
      2'd0:    w_op = op0_i;
      2'd1:    w_op = op1_i;
      2'd2:    w_op = op2_i;
      default: w_op = op3_i;
    endcase
  end

  assign w_mode = w_op[2*W];
  assign w_a    = w_op[2*W-1:W];
  assign w_b    = w_op[W-1:0];
  // The MSB of the 9-bit difference is the borrow, i.e. (a < b).
  assign w_sum  = w_mode ? ({1'b0, w_a} + {1'b0, w_b})
                         : ({1'b0, w_a} - {1'b0, w_b});

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ready <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_gidx  <= 2'd0;
`ifndef ADDSUB_FIXED_PRIO_EN
      r_ptr   <= 2'd0;
`endif
    end else if (w_found) begin
      r_ready <= {{(NP-1){1'b0}}, 1'b1} << w_win;
      r_res   <= w_sum[W-1:0];
      r_carry <= w_sum[W];
      r_gidx  <= w_win;
`ifndef ADDSUB_FIXED_PRIO_EN
      r_ptr   <= w_win + 2'd1;
`endif
    end else begin
      r_ready <= '0;
    end
  end

  assign ready_o = r_ready;
  assign res_o   = r_res;
  assign carry_o = r_carry;
  assign gidx_o  = r_gidx;
  assign busy_o  = (|req_i) | (|r_ready);

endmodule

// File: tb/tb_addsub_rr_server.sv
// Scoreboard bench for addsub_rr_server: directed vectors, expected grants queued,
// a monitor compares whenever ready_o is non-zero.
module tb_addsub_rr_server;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [16:0] op0 = '0, op1 = '0, op2 = '0, op3 = '0;
  logic [3:0]  ready_o;
  logic [7:0]  res_o;
  logic        carry_o;
  logic [1:0]  gidx_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] rdy;
    logic [7:0] res;
    logic       c;
    logic [1:0] g;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  addsub_rr_server #(.W(8), .NP(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req),
    .op0_i(op0), .op1_i(op1), .op2_i(op2), .op3_i(op3),
    .ready_o(ready_o), .res_o(res_o), .carry_o(carry_o),
    .gidx_o(gidx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Monitor: every valid output must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ready_o != 4'd0) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_ready: ready=%b res=%0d carry=%0d gidx=%0d, none expected",
                   ready_o, res_o, carry_o, gidx_o);
        end else begin
          mon_e = q.pop_front();
          if ({ready_o, res_o, carry_o, gidx_o} !== mon_e) begin
            n_errors++;
            $display("FAIL grant: got ready=%b res=%0d carry=%0d gidx=%0d, expected ready=%b res=%0d carry=%0d gidx=%0d",
                     ready_o, res_o, carry_o, gidx_o, mon_e.rdy, mon_e.res, mon_e.c, mon_e.g);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: apply req at negedge, queue the expected grant (if any),
  // and after the edge confirm ready_o stays low when no grant is expected.
  task automatic cyc(input logic [3:0] r, input logic [3:0] er,
                     input logic [7:0] eres, input logic ec, input logic [1:0] eg);
    @(negedge clk);
    req = r;
    if (er != 4'd0) q.push_back({er, eres, ec, eg});
    @(posedge clk);
    #1;
    if (er == 4'd0) chk("ready_idle", int'(ready_o), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_res", int'(res_o), 0);
    chk("rst_carry", int'(carry_o), 0);
    chk("rst_gidx", int'(gidx_o), 0);
  endtask

  initial begin
    #12;
    chk("por_ready", int'(ready_o), 0);
    chk("por_res", int'(res_o), 0);
    chk("por_carry", int'(carry_o), 0);
    chk("por_gidx", int'(gidx_o), 0);
    chk("por_busy", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on port 1: 200+100 = 300 -> res 44, carry 1.
    op1 = {1'b1, 8'd200, 8'd100};
    cyc(4'b0010, 4'b0010, 8'd44, 1'b1, 2'd1);
    chk("busy_req", int'(busy_o), 1);
    cyc(4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0);
    chk("hold_res44", int'(res_o), 44);
    chk("idle_busy", int'(busy_o), 0);

    // Subtracts on port 0: 3-5 wraps with borrow, 9-4 without.
    op0 = {1'b0, 8'd3, 8'd5};
    cyc(4'b0001, 4'b0001, 8'd254, 1'b1, 2'd0);
    cyc(4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0);
    op0 = {1'b0, 8'd9, 8'd4};
    cyc(4'b0001, 4'b0001, 8'd5, 1'b0, 2'd0);
    cyc(4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0);

    // Port 2 alone for 5 cycles: grants on alternate cycles, result held between.
    op2 = {1'b1, 8'd10, 8'd20};
    cyc(4'b0100, 4'b0100, 8'd30, 1'b0, 2'd2);
    cyc(4'b0100, 4'b0000, 8'd0, 1'b0, 2'd0);
    chk("mask_hold_res", int'(res_o), 30);
    cyc(4'b0100, 4'b0100, 8'd30, 1'b0, 2'd2);
    cyc(4'b0100, 4'b0000, 8'd0, 1'b0, 2'd0);
    cyc(4'b0100, 4'b0100, 8'd30, 1'b0, 2'd2);
    cyc(4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0);

    // All four ports continuously from reset.
    async_reset();
    @(negedge clk);
    rst_n = 1'b1;
    op0 = {1'b1, 8'd1,   8'd2};  // 3, c0
    op1 = {1'b0, 8'd50,  8'd20}; // 30, c0
    op2 = {1'b1, 8'd255, 8'd1};  // 0, c1
    op3 = {1'b0, 8'd0,   8'd1};  // 255, c1
`ifdef ADDSUB_FIXED_PRIO_EN
    cyc(4'b1111, 4'b1000, 8'd255, 1'b1, 2'd3);
    cyc(4'b1111, 4'b0100, 8'd0,   1'b1, 2'd2);
    cyc(4'b1111, 4'b1000, 8'd255, 1'b1, 2'd3);
    cyc(4'b1111, 4'b0100, 8'd0,   1'b1, 2'd2);
    cyc(4'b1111, 4'b1000, 8'd255, 1'b1, 2'd3);
`else
    cyc(4'b1111, 4'b0001, 8'd3,   1'b0, 2'd0);
    cyc(4'b1111, 4'b0010, 8'd30,  1'b0, 2'd1);
    cyc(4'b1111, 4'b0100, 8'd0,   1'b1, 2'd2);
    cyc(4'b1111, 4'b1000, 8'd255, 1'b1, 2'd3);
    cyc(4'b1111, 4'b0001, 8'd3,   1'b0, 2'd0);
`endif
    cyc(4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0);

    // Reset mid-operation while a grant is on the outputs.
    async_reset();
    @(negedge clk);
    rst_n = 1'b1;
    op0 = {1'b1, 8'd7,   8'd8};
    op3 = {1'b1, 8'd128, 8'd128};
`ifdef ADDSUB_FIXED_PRIO_EN
    cyc(4'b1001, 4'b1000, 8'd0, 1'b1, 2'd3);
`else
    cyc(4'b1001, 4'b0001, 8'd15, 1'b0, 2'd0);
`endif
    async_reset();
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    req = 4'b1001;
    q.push_back(0);
    q.pop_back();
`ifdef ADDSUB_FIXED_PRIO_EN
    q.push_back({4'b1000, 8'd0, 1'b1, 2'd3});
`else
    q.push_back({4'b0001, 8'd15, 1'b0, 2'd0});
`endif
    @(posedge clk);
    #1;
    cyc(4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0);
    chk("idle_busy_end", int'(busy_o), 0);
`ifdef ADDSUB_FIXED_PRIO_EN
    chk("idle_hold_res", int'(res_o), 0);
`else
    chk("idle_hold_res", int'(res_o), 15);
`endif
    cyc(4'b0000, 4'b0000, 8'd0, 1'b0, 2'd0);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
